block_main_memory: RTL and testbench

//  Parametrised main memory behind the cache. Serves whole-block reads/writes

---
 rtl/block_main_memory_pkg.sv | 23 ++
 rtl/mem_latency_counter.sv | 43 ++++
 rtl/block_main_memory.sv | 136 +++++++++++++
 tb/tb_block_main_memory.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/block_main_memory_pkg.sv
// rtl/block_main_memory_pkg.sv - shared types, defaults and helpers for block_main_memory
// Purpose : FSM state encoding, default parameter values and the block-offset
//           width helper shared by the memory top and its latency counter.
// Ports   : none (package)
package block_main_memory_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_LATENCY     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Number of byte-offset bits inside one block.
    function automatic int off_w(input int block_words, input int word_w);
        return $clog2(block_words * word_w / 8);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// rtl/mem_latency_counter.sv - loadable down-counter with zero flag for access timing
// Purpose : Holds the remaining cycles of an in-flight access. Loaded with a
//           start value, decremented on request, saturates at zero.
// Ports   : clk_i        rising-edge clock
//           reset_i      synchronous active-high reset (count -> 0)
//           load_i       load load_val_i (has priority over dec_i)
//           load_val_i   start value
//           dec_i        decrement by one (no effect at zero)
//           zero_o       count is zero
module mem_latency_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/block_main_memory.sv
// rtl/block_main_memory.sv - block-granular main memory with programmable access latency
// Purpose : Serves whole-block reads and writes over a req/ready handshake.
//           One access in flight; request fields are latched on acceptance and
//           the access is performed LATENCY edges later, followed by a single
//           ready cycle.
// Ports   : clk    rising-edge clock
//           reset  synchronous active-high reset
//           req    access request, sampled only in IDLE
//           we     1 = block write, 0 = block read
//           addr   byte address; block offset bits ignored
//           wdata  write block, word k at [k*WORD_W +: WORD_W]
//           rdata  last completed read block, same word ordering
//           ready  one-cycle completion pulse
//           busy   high while an access is in flight
module block_main_memory
    import block_main_memory_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [BLOCK_WORDS*WORD_W-1:0] wdata,
    output logic [BLOCK_WORDS*WORD_W-1:0] rdata,
    output logic                          ready,
    output logic                          busy
);

    localparam int OFF_W      = off_w(BLOCK_WORDS, WORD_W);
    localparam int IDX_W      = ADDR_W - OFF_W;
    localparam int NUM_BLOCKS = 2 ** IDX_W;
    localparam int BLK_W      = BLOCK_WORDS * WORD_W;
    localparam int CNT_W      = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    mem_state_e        state_q;
    mem_state_e        state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              we_q;
    logic [BLK_W-1:0]  wdata_q;
    logic [BLK_W-1:0]  rdata_q;

    logic              accept;
    logic              dec;
    logic              access;
    logic              cnt_zero;

    // Storage is one entry per block: word k of block i sits at bits
    // [k*WORD_W +: WORD_W], which is the word-address order {i, k}.
    // Deliberately outside the reset domain; the initialiser only gives
    // simulation a defined starting image.
    logic [BLK_W-1:0]  mem_q [NUM_BLOCKS] = '{default: '0};

    // Byte-offset bits select nothing inside a whole-block access.
    if (OFF_W > 0) begin : g_off
        logic unused_off;
        assign unused_off = ^addr[OFF_W-1:0];
    end

    mem_latency_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (accept),
        .load_val_i (LOAD_VAL),
        .dec_i      (dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        dec     = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_zero) begin
                    access  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q   <= addr[ADDR_W-1:OFF_W];
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (access && !we_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // Reset on the commit edge aborts the write as well as the FSM.
    always_ff @(posedge clk) begin
        if (!reset && access && we_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = (state_q == ST_DONE);
    assign busy  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_block_main_memory.sv
// tb/tb_block_main_memory.sv - directed table-driven bench for block_main_memory
module tb_block_main_memory;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic         we = 1'b0;
    logic [9:0]   addr = '0;
    logic [127:0] wdata = '0;
    logic [127:0] rdata_a, rdata_b;
    logic         ready_a, ready_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_main_memory #(
        .ADDR_W(10), .WORD_W(32), .BLOCK_WORDS(4), .LATENCY(LAT_A)
    ) dut_a (
        .clk(clk), .reset(rst), .req(req_a), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .busy(busy_a)
    );

    block_main_memory #(
        .ADDR_W(10), .WORD_W(16), .BLOCK_WORDS(8), .LATENCY(LAT_B)
    ) dut_b (
        .clk(clk), .reset(rst), .req(req_b), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .busy(busy_b)
    );

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    typedef struct {
        int           sel;
        logic         we;
        logic [9:0]   addr;
        logic [127:0] wdata;
        logic [127:0] exp_rd;
    } vec_t;

    localparam logic [127:0] B1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] B2 = 128'hDEADBEEF_CAFEBABE_0BADF00D_12345678;
    localparam logic [127:0] B3 = 128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A;
    localparam logic [127:0] B4 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] B5 = 128'h55550000_55551111_55552222_55553333;
    localparam logic [127:0] B6 = 128'h66666666_66666666_66666666_66666666;
    localparam logic [127:0] B7 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [127:0] B8 = 128'h8001_8002_8003_8004_8005_8006_8007_8008;
    localparam logic [127:0] B9 = 128'h99999999_99999999_99999999_99999999;

    vec_t vecs[13];

    task automatic run_access(input int sel, input logic w, input logic [9:0] a,
                              input logic [127:0] d, output int lat);
        bit found;
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        lat = -1;
        found = 1'b0;
        for (int i = 1; i <= 50 && !found; i++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? ready_a : ready_b) begin
                lat = i;
                found = 1'b1;
            end
        end
        // step past the DONE cycle so the next access starts from IDLE
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int busy_cnt, rdy_cnt;
        logic [127:0] rd;
        logic [31:0]  w0;

        vecs[0]  = '{0, 1'b1, 10'h040, B1, 128'h0};
        vecs[1]  = '{0, 1'b0, 10'h04C, '0, B1};
        vecs[2]  = '{0, 1'b1, 10'h3F0, B2, B1};
        vecs[3]  = '{0, 1'b0, 10'h3FF, '0, B2};
        vecs[4]  = '{0, 1'b0, 10'h040, '0, B1};
        vecs[5]  = '{0, 1'b1, 10'h000, B4, B1};
        vecs[6]  = '{0, 1'b1, 10'h100, B5, B1};
        vecs[7]  = '{0, 1'b0, 10'h108, '0, B5};
        vecs[8]  = '{0, 1'b0, 10'h200, '0, 128'h0};
        vecs[9]  = '{1, 1'b1, 10'h020, B7, 128'h0};
        vecs[10] = '{1, 1'b0, 10'h02E, '0, B7};
        vecs[11] = '{1, 1'b1, 10'h3F0, B8, B7};
        vecs[12] = '{1, 1'b0, 10'h3F8, '0, B8};

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready_a", {127'b0, ready_a}, 128'h0);
        chk("reset_busy_a", {127'b0, busy_a}, 128'h0);
        chk("reset_rdata_a", rdata_a, 128'h0);
        chk("reset_ready_b", {127'b0, ready_b}, 128'h0);
        chk("reset_busy_b", {127'b0, busy_b}, 128'h0);
        chk("reset_rdata_b", rdata_b, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[v]) begin
            run_access(vecs[v].sel, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat);
            chk($sformatf("vec%0d_latency", v), 128'(lat),
                128'((vecs[v].sel == 0) ? LAT_A : LAT_B));
            rd = (vecs[v].sel == 0) ? rdata_a : rdata_b;
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            chk($sformatf("vec%0d_idle_after", v),
                {126'b0, ((vecs[v].sel == 0) ? ready_a : ready_b),
                         ((vecs[v].sel == 0) ? busy_a : busy_b)}, 128'h0);
            if (v == 1) begin
                w0 = rdata_a[31:0];
                chk("vec1_word0", 128'(w0), 128'h11111111);
            end
        end

        // req held high while busy, address/we changed mid-access
        @(negedge clk);
        req_a = 1'b1; we = 1'b0; addr = 10'h000; wdata = '0;
        busy_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (busy_a) busy_cnt++;
            if (ready_a) rdy_cnt++;
            @(negedge clk);
            if (i == 0) begin addr = 10'h100; we = 1'b1; wdata = B9; end
            if (i == 4) req_a = 1'b0;
        end
        chk("held_busy_cycles", 128'(busy_cnt), 128'(LAT_A));
        chk("held_ready_pulses", 128'(rdy_cnt), 128'h1);
        chk("held_rdata", rdata_a, B4);
        run_access(0, 1'b0, 10'h104, '0, lat);
        chk("held_no_write", rdata_a, B5);

        // reset in the second cycle of a write to 0x080
        @(negedge clk);
        req_a = 1'b1; we = 1'b1; addr = 10'h080; wdata = B6;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready_a) rdy_cnt++;
            if (busy_a) busy_cnt++;
        end
        chk("abort_no_ready", 128'(rdy_cnt), 128'h0);
        chk("abort_no_busy", 128'(busy_cnt), 128'h0);
        chk("abort_rdata_cleared", rdata_a, 128'h0);
        run_access(0, 1'b0, 10'h080, '0, lat);
        chk("abort_read_latency", 128'(lat), 128'(LAT_A));
        chk("abort_read_old", rdata_a, 128'h0);

        // reset and req together: request discarded
        @(negedge clk);
        rst = 1'b1; req_a = 1'b1; we = 1'b0; addr = 10'h040;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_a = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy_a || ready_a) busy_cnt++;
        end
        chk("reset_req_discarded", 128'(busy_cnt), 128'h0);
        chk("reset_req_rdata", rdata_a, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
